// File: rtl/imuldiv_int_div_iterative_if.sv
// Request/response bundle for the iterative divider: val/rdy request carrying
// fn/a/b, and a val/rdy response carrying {remainder, quotient}.
interface imuldiv_int_div_iterative_if;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a;
  logic [31:0] divreq_msg_b;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val;
  logic        divresp_rdy;

  modport master (
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    input  divreq_rdy,
    input  divresp_msg_result, divresp_val,
    output divresp_rdy
  );

  modport slave (
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    output divreq_rdy,
    output divresp_msg_result, divresp_val,
    input  divresp_rdy
  );
endinterface

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per
// cycle; responds with {remainder, quotient} after 32 iterations.
module imuldiv_int_div_iterative (
  input  logic                          clk,
  input  logic                          reset_n,
  imuldiv_int_div_iterative_if.slave    io_div
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_dz;
  logic [31:0] r_a_orig;
  logic [31:0] r_b_abs;
  logic [64:0] r_work;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_last;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [64:0] w_work_nxt;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_result;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  assign w_accept = io_div.divreq_val && (r_state == ST_IDLE);
  assign w_last   = (r_cnt == 5'd31);
  assign w_sign_a = io_div.divreq_msg_a[31] & ~io_div.divreq_msg_fn;
  assign w_sign_b = io_div.divreq_msg_b[31] & ~io_div.divreq_msg_fn;

  // Handshake outputs decode straight from the registered state.
  assign io_div.divreq_rdy         = (r_state == ST_IDLE);
  assign io_div.divresp_val        = (r_state == ST_DONE);
  assign io_div.divresp_msg_result = r_result;

  // One restoring step: a negative 33-bit difference (bit 32 set) keeps the partial remainder.
  always_comb begin
    w_shift = r_work << 1;
    w_diff  = w_shift[64:32] - {1'b0, r_b_abs};
    if (!w_diff[32]) begin
      w_work_nxt = {w_diff, w_shift[31:1], 1'b1};
    end else begin
      w_work_nxt = w_shift;
    end
  end

  // Sign fix-up of the final step; divide-by-zero overrides it.
  always_comb begin
    w_quot = w_work_nxt[31:0];
    w_rem  = w_work_nxt[63:32];
    if (r_dz) begin
      w_result = {r_a_orig, 32'hFFFF_FFFF};
    end else begin
      w_result = {(r_sign_a ? neg32(w_rem) : w_rem),
                  ((r_sign_a ^ r_sign_b) ? neg32(w_quot) : w_quot)};
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io_div.divreq_val) w_state_nxt = ST_CALC;
        else                   w_state_nxt = ST_IDLE;
      end
      ST_CALC: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_CALC;
      end
      ST_DONE: begin
        if (io_div.divresp_rdy) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 5'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= 32'd0;
      r_b_abs  <= 32'd0;
      r_work   <= 65'd0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_dz     <= (io_div.divreq_msg_b == 32'd0);
            r_a_orig <= io_div.divreq_msg_a;
            r_b_abs  <= w_sign_b ? neg32(io_div.divreq_msg_b) : io_div.divreq_msg_b;
            r_work   <= {33'd0, (w_sign_a ? neg32(io_div.divreq_msg_a) : io_div.divreq_msg_a)};
            r_cnt    <= 5'd0;
          end
        end
        ST_CALC: begin
          r_work <= w_work_nxt;
          if (w_last) begin
            r_result <= w_result;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_DONE: begin
          r_result <= r_result;
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

endmodule
